// File: rtl/tl_ul_host_arbiter.sv
// tl_ul_host_arbiter
//   N-host to 1-device TileLink-UL style arbiter. Hosts are granted
//   round-robin. Only one transaction may be outstanding at a time. Each D
//   response is routed back to the host that issued the request.
//
//   Optional feature: define TL_ARB_TIMEOUT_EN to enable a response watchdog.
//   When a response does not arrive within TIMEOUT_CYCLES RESP cycles, the
//   arbiter completes the transaction towards the host with an error.
//
//   Ports
//     clk, reset                  clock, asynchronous active-low reset
//     h_a_valid/ready             per-host A handshake
//     h_a_opcode/address/data/mask  per-host A fields, packed host-major
//     h_d_valid                   per-host response strobe (one-hot or zero)
//     h_d_opcode/data/error       registered response fields, shared
//     a_*                         device A channel (a_source = granted host)
//     d_*                         device D channel
module tl_ul_host_arbiter #(
  parameter int NUM_HOSTS      = 2,
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int SRC_W          = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_HOSTS-1:0]          h_a_valid,
  output logic [NUM_HOSTS-1:0]          h_a_ready,
  input  logic [3*NUM_HOSTS-1:0]        h_a_opcode,
  input  logic [ADDR_W*NUM_HOSTS-1:0]   h_a_address,
  input  logic [DATA_W*NUM_HOSTS-1:0]   h_a_data,
  input  logic [DATA_W/8*NUM_HOSTS-1:0] h_a_mask,
  output logic [NUM_HOSTS-1:0]          h_d_valid,
  output logic [2:0]                    h_d_opcode,
  output logic [DATA_W-1:0]             h_d_data,
  output logic                          h_d_error,
  output logic                          a_valid,
  input  logic                          a_ready,
  output logic [2:0]                    a_opcode,
  output logic [ADDR_W-1:0]             a_address,
  output logic [DATA_W-1:0]             a_data,
  output logic [DATA_W/8-1:0]           a_mask,
  output logic [SRC_W-1:0]              a_source,
  input  logic                          d_valid,
  output logic                          d_ready,
  input  logic [2:0]                    d_opcode,
  input  logic [DATA_W-1:0]             d_data,
  input  logic [SRC_W-1:0]              d_source,
  input  logic                          d_error
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state, state_nxt;
  logic [SRC_W-1:0]    rr_ptr, g, gnt_idx, hi_idx, lo_idx, next_ptr;
  logic                hi_any, lo_any, gnt_any;
  logic [NUM_HOSTS-1:0] gnt_oh, resp_oh;
  logic [2:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [MASK_W-1:0]   sel_mask;
  logic                timeout_fire;

  // Round-robin pick: the lowest requester at or above rr_ptr wins.
  // Otherwise, wrap to the lowest requester overall.
  always_comb begin
    hi_any = 1'b0;
    hi_idx = '0;
    lo_any = 1'b0;
    lo_idx = '0;
    for (int unsigned i = 0; i < NUM_HOSTS; i++) begin
      if (h_a_valid[i]) begin
        if (!lo_any) begin
          lo_any = 1'b1;
          lo_idx = SRC_W'(i);
        end
        if (!hi_any && SRC_W'(i) >= rr_ptr) begin
          hi_any = 1'b1;
          hi_idx = SRC_W'(i);
        end
      end
    end
    gnt_any = lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

  always_comb begin
    gnt_oh   = '0;
    resp_oh  = '0;
    sel_op   = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_mask = '0;
    for (int unsigned i = 0; i < NUM_HOSTS; i++) begin
      resp_oh[i] = (SRC_W'(i) == g);
      if (SRC_W'(i) == gnt_idx) begin
        gnt_oh[i] = gnt_any;
        sel_op    = h_a_opcode[i*3 +: 3];
        sel_addr  = h_a_address[i*ADDR_W +: ADDR_W];
        sel_data  = h_a_data[i*DATA_W +: DATA_W];
        sel_mask  = h_a_mask[i*MASK_W +: MASK_W];
      end
    end
  end

  assign next_ptr = (g == SRC_W'(NUM_HOSTS - 1)) ? '0 : g + SRC_W'(1);
  assign a_source = g;

`ifdef TL_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // This fires on the TIMEOUT_CYCLES-th consecutive RESP cycle without d_valid.
  assign timeout_fire = (state == RESP) && !d_valid &&
                        (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == REQ) begin
      tmo_cnt <= '0;
    end else if (state == RESP && !d_valid) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt_any) state_nxt = REQ;
      REQ:     if (a_ready) state_nxt = RESP;
      RESP:    if (d_valid || timeout_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs. h_a_ready is gated by reset because it is otherwise a
  // combinational function of h_a_valid while the machine sits in IDLE.
  always_comb begin
    a_valid   = 1'b0;
    d_ready   = 1'b0;
    h_a_ready = '0;
    unique case (state)
      IDLE:    if (reset) h_a_ready = gnt_oh;
      REQ:     a_valid = 1'b1;
      RESP:    d_ready = 1'b1;
      default: ;
    endcase
  end

  // Registered A fields, grant index, round-robin pointer and host responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_opcode   <= '0;
      a_address  <= '0;
      a_data     <= '0;
      a_mask     <= '0;
      g          <= '0;
      rr_ptr     <= '0;
      h_d_valid  <= '0;
      h_d_opcode <= '0;
      h_d_data   <= '0;
      h_d_error  <= 1'b0;
    end else begin
      h_d_valid <= '0;
      if (state == IDLE && gnt_any) begin
        a_opcode  <= sel_op;
        a_address <= sel_addr;
        a_data    <= sel_data;
        a_mask    <= sel_mask;
        g         <= gnt_idx;
      end
      if (state == RESP && d_valid) begin
        h_d_valid  <= resp_oh;
        h_d_opcode <= d_opcode;
        h_d_data   <= d_data;
        h_d_error  <= d_error | (d_source != g);
        rr_ptr     <= next_ptr;
      end else if (timeout_fire) begin
        h_d_valid  <= resp_oh;
        h_d_opcode <= (a_opcode == 3'b100) ? 3'b001 : 3'b000;
        h_d_data   <= '0;
        h_d_error  <= 1'b1;
        rr_ptr     <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_tl_ul_host_arbiter.sv
// tb_tl_ul_host_arbiter
//   Directed and randomized bench for tl_ul_host_arbiter with default
//   parameters. The bench acts both as the hosts and as the device. A
//   round-robin model predicts the grants and the expected host responses.
module tb_tl_ul_host_arbiter;

  localparam int N  = 2;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = DW / 8;
  localparam int SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [N-1:0]      pend;
  logic [2:0]        hop   [N];
  logic [AW-1:0]     haddr [N];
  logic [DW-1:0]     hdat  [N];
  logic [MW-1:0]     hmsk  [N];

  logic [N-1:0]      h_a_ready, h_d_valid;
  logic [3*N-1:0]    h_a_opcode;
  logic [AW*N-1:0]   h_a_address;
  logic [DW*N-1:0]   h_a_data;
  logic [MW*N-1:0]   h_a_mask;
  logic [2:0]        h_d_opcode, a_opcode, d_opcode;
  logic [DW-1:0]     h_d_data, a_data, d_data;
  logic              h_d_error, a_valid, a_ready, d_valid, d_ready, d_error;
  logic [AW-1:0]     a_address;
  logic [MW-1:0]     a_mask;
  logic [SW-1:0]     a_source, d_source;

  always_comb begin
    h_a_opcode  = '0;
    h_a_address = '0;
    h_a_data    = '0;
    h_a_mask    = '0;
    for (int h = 0; h < N; h++) begin
      h_a_opcode[h*3 +: 3]   = hop[h];
      h_a_address[h*AW +: AW] = haddr[h];
      h_a_data[h*DW +: DW]   = hdat[h];
      h_a_mask[h*MW +: MW]   = hmsk[h];
    end
  end

  tl_ul_host_arbiter #(
    .NUM_HOSTS(N), .ADDR_W(AW), .DATA_W(DW), .SRC_W(SW), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .reset(reset),
    .h_a_valid(pend), .h_a_ready(h_a_ready), .h_a_opcode(h_a_opcode),
    .h_a_address(h_a_address), .h_a_data(h_a_data), .h_a_mask(h_a_mask),
    .h_d_valid(h_d_valid), .h_d_opcode(h_d_opcode), .h_d_data(h_d_data),
    .h_d_error(h_d_error),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_address(a_address), .a_data(a_data), .a_mask(a_mask),
    .a_source(a_source),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_data(d_data), .d_source(d_source), .d_error(d_error)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int          rr;
  bit          hd_pend;
  logic [N-1:0] e_hv;
  logic [2:0]  e_hop;
  logic [DW-1:0] e_hd;
  logic        e_herr;
  int          gq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int h, input logic [2:0] op, input logic [AW-1:0] ad,
                         input logic [DW-1:0] da, input logic [MW-1:0] mk);
    hop[h] = op; haddr[h] = ad; hdat[h] = da; hmsk[h] = mk;
    pend[h] = 1'b1;
  endtask

  task automatic rnd_req(input int h);
    set_req(h, ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b000, AW'($urandom),
            $urandom, MW'($urandom));
  endtask

  function automatic int pred_grant();
    for (int i = 0; i < N; i++)
      if (pend[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  // Checks the response that the previous transaction left registered.
  task automatic chk_resp();
    if (hd_pend) begin
      chk("h_d_valid", h_d_valid, e_hv);
      chk("h_d_opcode", h_d_opcode, e_hop);
      chk("h_d_data", h_d_data, e_hd);
      chk("h_d_error", h_d_error, e_herr);
      hd_pend = 0;
    end else begin
      chk("h_d_valid_quiet", h_d_valid, 0);
    end
  endtask

  // One complete transaction. On entry, the DUT is in IDLE, the inputs have
  // just been driven after a rising edge, and at least one host is pending.
  task automatic txn(input int adly, input int ddly, input bit wrong, input bit again,
                     input logic [2:0] rop, input logic [DW-1:0] rdat, input bit rerr);
    int g, og;
    logic [N-1:0] eg;
    logic [2:0] op;
    logic [AW-1:0] ad;
    logic [DW-1:0] da;
    logic [MW-1:0] mk;
    g = pred_grant();
    eg = '0;
    eg[g] = 1'b1;
    op = hop[g]; ad = haddr[g]; da = hdat[g]; mk = hmsk[g];
    @(negedge clk);
    chk("grant", h_a_ready, eg);
    chk("a_valid_grant_cycle", a_valid, 0);
    chk_resp();
    og = -1;
    for (int h = 0; h < N; h++) if (h_a_ready[h]) og = h;
    gq.push_back(og);
    tick();
    pend[g] = 1'b0;
    if (again) rnd_req(g);
    for (int j = 0; j <= adly; j++) begin
      a_ready = (j == adly);
      @(negedge clk);
      chk("a_valid", a_valid, 1);
      chk("a_opcode", a_opcode, op);
      chk("a_address", a_address, ad);
      chk("a_data", a_data, da);
      chk("a_mask", a_mask, mk);
      chk("a_source", a_source, g);
      chk("h_a_ready_req", h_a_ready, 0);
      chk("d_ready_req", d_ready, 0);
      tick();
    end
    a_ready = 1'b0;
    for (int j = 0; j <= ddly; j++) begin
      if (j == ddly) begin
        d_valid  = 1'b1;
        d_opcode = rop;
        d_data   = rdat;
        d_error  = rerr;
        d_source = SW'(wrong ? (g ^ 1) : g);
      end
      @(negedge clk);
      chk("d_ready_resp", d_ready, 1);
      chk("a_valid_resp", a_valid, 0);
      chk("h_a_ready_resp", h_a_ready, 0);
      chk("h_d_valid_resp", h_d_valid, 0);
      tick();
    end
    d_valid = 1'b0; d_opcode = '0; d_data = '0; d_error = 1'b0; d_source = '0;
    e_hv = eg; e_hop = rop; e_hd = rdat; e_herr = rerr | wrong;
    hd_pend = 1;
    rr = (g + 1) % N;
  endtask

  task automatic drain();
    @(negedge clk);
    chk_resp();
    tick();
  endtask

  initial begin
    int c0;
    reset = 1'b0;
    pend = '0;
    for (int h = 0; h < N; h++) begin
      hop[h] = '0; haddr[h] = '0; hdat[h] = '0; hmsk[h] = '0;
    end
    a_ready = 0; d_valid = 0; d_opcode = '0; d_data = '0; d_error = 0; d_source = '0;
    rr = 0; hd_pend = 0;

    // Reset values. While in reset, host0 is already requesting.
    set_req(0, 3'b100, 12'h004, 32'h0, 4'hF);
    tick(); tick();
    @(negedge clk);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_h_a_ready", h_a_ready, 0);
    chk("rst_h_d_valid", h_d_valid, 0);
    chk("rst_h_d_data", h_d_data, 0);
    chk("rst_h_d_opcode", h_d_opcode, 0);
    chk("rst_h_d_error", h_d_error, 0);
    tick();
    reset = 1'b1;

    // Host0 Get at 0x004; the device returns AccessAckData 0xDEADBEEF.
    txn(0, 1, 0, 0, 3'b001, 32'hDEADBEEF, 0);
    drain();

    // Both hosts request continuously; the grants must alternate.
    gq.delete();
    rnd_req(0);
    rnd_req(1);
    for (int i = 0; i < 8; i++)
      txn($urandom_range(0, 2), $urandom_range(0, 2), 0, (i < 6),
          ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b000, $urandom, 0);
    drain();
    c0 = 0;
    for (int i = 0; i < 8; i++) if (gq[i] == 0) c0++;
    chk("fair_host0_count", c0, 4);
    for (int i = 1; i < 8; i++) chk("fair_alternate", (gq[i] != gq[i-1]), 1);

    // Host1 PutFullData. a_ready is held low for 5 cycles.
    set_req(1, 3'b000, 12'h404, 32'h12345678, 4'hF);
    txn(5, 0, 0, 0, 3'b000, 32'h0, 0);
    drain();

    // Wrong d_source: the response is routed to host0 with the error forced.
    set_req(0, 3'b100, 12'h010, 32'h0, 4'hF);
    txn(0, 0, 1, 0, 3'b001, 32'hCAFEF00D, 0);
    drain();

    // A d_valid while IDLE is ignored.
    d_valid = 1'b1; d_data = 32'h55AA55AA; d_opcode = 3'b001;
    @(negedge clk);
    chk("d_ready_idle", d_ready, 0);
    tick();
    d_valid = 1'b0; d_data = '0; d_opcode = '0;
    @(negedge clk);
    chk("h_d_valid_after_idle_d", h_d_valid, 0);
    chk("a_valid_after_idle_d", a_valid, 0);
    tick();

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      for (int h = 0; h < N; h++)
        if (!pend[h] && $urandom_range(0, 1) == 1) rnd_req(h);
      if (pend == '0) rnd_req(int'($urandom_range(0, N - 1)));
      txn($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1) ? 3'b001 : 3'b000,
          $urandom, ($urandom_range(0, 3) == 0));
    end
    // Clear any pending requests through normal transactions.
    while (pend != '0)
      txn(0, 0, 0, 0, 3'b000, $urandom, 0);
    drain();

    // Reset while in RESP: outputs clear at once and no response is issued.
    rnd_req(1);
    @(negedge clk);
    chk("rst_mid_grant", h_a_ready, 2'b10);
    chk_resp();
    tick();
    pend[1] = 1'b0;
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_resp", d_ready, 1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_d_ready", d_ready, 0);
    chk("rst_mid_a_valid", a_valid, 0);
    chk("rst_mid_h_d_valid", h_d_valid, 0);
    chk("rst_mid_a_source", a_source, 0);
    rnd_req(0);
    rnd_req(1);
    d_valid = 1'b1; d_source = 3'd1; d_data = 32'h11112222; d_opcode = 3'b001;
    @(negedge clk);
    chk("rst_mid_h_a_ready", h_a_ready, 0);
    tick(); tick();
    d_valid = 1'b0; d_source = '0; d_data = '0; d_opcode = '0;
    reset = 1'b1;
    rr = 0;
    hd_pend = 0;
    txn(0, 0, 0, 0, 3'b001, $urandom, 0);
    chk("rst_mid_next_host0", gq[gq.size() - 1], 0);
    txn(0, 0, 0, 0, 3'b000, $urandom, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tl_ul_host_arbiter.md
Name: tl_ul_host_arbiter

Overview:
- Parametrised N-host to 1-device TileLink-UL style arbiter for core bus traffic: instruction fetch, data load/store, and later additional masters.
- Replaces fixed per-channel request/response wiring with round-robin arbitration and valid/ready handshakes on both A and D channels.
- Tracks one outstanding transaction at a time and routes each D response back to the host that issued the request.

Parameters:
- NUM_HOSTS, 2, number of requesting hosts (1..8).
- ADDR_W, 12, address width.
- DATA_W, 32, data width; a multiple of 8.
- SRC_W, 3, source-ID width; must be >= clog2(NUM_HOSTS).
- TIMEOUT_CYCLES, 255, response watchdog limit; used only with TL_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- h_a_valid  in  NUM_HOSTS  per-host request valid.
- h_a_ready  out  NUM_HOSTS  per-host request accepted.
- h_a_opcode  in  3*NUM_HOSTS  per-host opcode: 3'b100 Get, 3'b000 PutFullData.
- h_a_address  in  ADDR_W*NUM_HOSTS  per-host address.
- h_a_data  in  DATA_W*NUM_HOSTS  per-host write data.
- h_a_mask  in  (DATA_W/8)*NUM_HOSTS  per-host byte mask.
- h_d_valid  out  NUM_HOSTS  per-host response valid; one-hot or zero.
- h_d_opcode  out  3  response opcode, shared by all hosts.
- h_d_data  out  DATA_W  response data, shared by all hosts.
- h_d_error  out  1  response error, shared by all hosts.
- a_valid  out  1  device request valid.
- a_ready  in  1  device accepts request.
- a_opcode  out  3  device request opcode.
- a_address  out  ADDR_W  device request address.
- a_data  out  DATA_W  device write data.
- a_mask  out  DATA_W/8  device byte mask.
- a_source  out  SRC_W  index of the granted host.
- d_valid  in  1  device response valid.
- d_ready  out  1  arbiter accepts response.
- d_opcode  in  3  3'b000 AccessAck, 3'b001 AccessAckData.
- d_data  in  DATA_W  response data.
- d_source  in  SRC_W  echoed source ID.
- d_error  in  1  device error flag.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, rr_ptr=0, all registered A fields=0.
- Output values during reset: a_valid=0, d_ready=0, h_a_ready=0, h_d_valid=0, h_d_data=0, h_d_opcode=0, h_d_error=0.
- State machine: IDLE -> REQ -> RESP -> IDLE.
- IDLE:
  - Pick the first requesting host scanning from rr_ptr upward, with modulo NUM_HOSTS wrap.
  - Assert h_a_ready[g] for exactly one cycle.
  - Latch that host's opcode, address, data, mask and g into registers.
  - Go to REQ.
  - No request pending: stay in IDLE.
- REQ:
  - a_valid=1 with the registered fields; a_source=g.
  - Fields are held stable until a_valid && a_ready.
  - On that handshake go to RESP.
- RESP:
  - d_ready=1.
  - On d_valid: drive h_d_valid[g]=1 for one cycle with h_d_opcode=d_opcode, h_d_data=d_data, h_d_error=d_error.
  - Set rr_ptr=(g+1) mod NUM_HOSTS, then go to IDLE.
  - h_d_* outputs are registered, so the response reaches the host one cycle after the D handshake.
- d_source != g while in RESP:
  - Response is still consumed and routed to g.
  - h_d_error is forced to 1.
- d_valid outside RESP: d_ready=0, response ignored, no state change.
- Latency: host valid to a_valid = 2 cycles (grant cycle plus register); minimum host-to-host turnaround = 4 cycles.
- Fairness: with every host requesting continuously, grants rotate 0,1,...,NUM_HOSTS-1,0,...
- Simultaneous events: a new h_a_valid during REQ or RESP is held off (h_a_ready=0) until the next IDLE.
- Reset mid-transaction: the transaction is abandoned, no h_d_valid is issued, and the machine restarts in IDLE with rr_ptr=0.
- Hosts must hold h_a_* stable while h_a_valid=1 and h_a_ready=0.

Optional Feature:
- Macro: TL_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to RESP and increments each RESP cycle without d_valid.
  - When the count reaches TIMEOUT_CYCLES: issue h_d_valid[g]=1, h_d_error=1, h_d_data=0, h_d_opcode = 3'b001 for Get or 3'b000 for Put; go to IDLE.
  - Once timed out, d_ready stays 0 until the next RESP.
- Undefined: no counter; RESP waits indefinitely.

Test Plan:
- Reset release, host0 Get at addr 0x004, device returns AccessAckData 0xDEADBEEF -> a_valid 2 cycles after h_a_valid, a_source=0, h_d_valid=2'b01, h_d_data=0xDEADBEEF, h_d_error=0.
- Both hosts request every cycle for 8 transactions -> grant order 0,1,0,1,0,1,0,1; no host starved.
- Host1 PutFullData addr 0x404, data 0x12345678, mask 4'hF, with a_ready held low 5 cycles -> a_* fields stable throughout, a_opcode=3'b000, single handshake, h_d_valid=2'b10 with opcode 3'b000.
- Response with d_source=1 while g=0 -> h_d_valid=2'b01 with h_d_error=1.
- Reset driven low while in RESP -> outputs 0 immediately (asynchronous), no h_d_valid issued, next grant goes to host0.
- With TL_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=10, d_valid never asserted -> h_d_valid with h_d_error=1 and h_d_data=0 after 10 RESP cycles, then IDLE.
